// File: rtl/j_dsp_lbus_pkg.sv
// Shared types for the DSP local-bus arbiter: address regions, FSM states,
// requester ids and the default host streak limit.
package j_dsp_lbus_pkg;

  localparam int STREAK_MAX_DEF = 4;

  typedef enum logic [1:0] {
    REG_RAM0 = 2'b00,
    REG_RAM1 = 2'b01,
    REG_ROM  = 2'b10,
    REG_NONE = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RETURN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ID_HOST = 2'd0,
    ID_LSU  = 2'd1,
    ID_PF   = 2'd2
  } id_e;

  // The 12-bit word address carries byte bits [13:2], so [11:10] is byte [13:12].
  function automatic region_e decode_region(input logic [11:0] addr);
    return region_e'(addr[11:10]);
  endfunction

endpackage

// File: rtl/j_dsp_lbus_rr.sv
// Grant selection for the local bus: host priority bounded by a streak limit,
// round-robin between the load/store unit and instruction prefetch.
module j_dsp_lbus_rr
  import j_dsp_lbus_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_host_elig,
  input  logic i_lsu_elig,
  input  logic i_pf_elig,
  input  logic i_take,
  output logic o_valid,
  output id_e  o_id
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  logic [SW-1:0] r_streak;
  logic          r_favour_pf;
  logic          w_int_elig;
  logic          w_streak_full;
  logic          w_pick_pf;

  always_comb begin
    o_valid       = i_host_elig | i_lsu_elig | i_pf_elig;
    w_int_elig    = i_lsu_elig | i_pf_elig;
    w_streak_full = (r_streak == SW'(STREAK_MAX));
    w_pick_pf     = i_pf_elig & (~i_lsu_elig | r_favour_pf);
    o_id          = ID_HOST;
    if (!i_host_elig || (w_streak_full && w_int_elig))
      o_id = w_pick_pf ? ID_PF : ID_LSU;
  end

  // Host grants count up and saturate; any internal grant clears the streak.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_streak    <= '0;
      r_favour_pf <= 1'b0;
    end else if (i_take && o_valid) begin
      if (o_id == ID_HOST) begin
        if (!w_streak_full)
          r_streak <= r_streak + SW'(1);
      end else begin
        r_streak    <= '0;
        r_favour_pf <= (o_id == ID_LSU);
      end
    end
  end

endmodule

// File: rtl/j_dsp_lbus_arb.sv
// Local-bus arbiter and address decoder in front of the DSP RAM/ROM port:
// one access in flight, fixed three-cycle request-to-ack latency.
module j_dsp_lbus_arb
  import j_dsp_lbus_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [11:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_ack,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [11:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ack,
  input  logic        pf_req,
  input  logic [11:0] pf_addr,
  output logic        pf_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [9:0]  ram_addr,
  output logic [1:0]  ramen,
  output logic        romen,
  output logic        gpu_memw,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  state_e      r_state;
  state_e      w_next;
  logic        r_we;
  logic        r_bad;
  id_e         r_id;
  logic        w_grant_valid;
  id_e         w_grant_id;
  logic [11:0] w_sel_addr;
  logic        w_sel_we;
  logic [31:0] w_sel_wdata;
  region_e     w_sel_region;
  logic        w_sel_bad;

  j_dsp_lbus_rr #(.STREAK_MAX(STREAK_MAX)) u_rr (
    .i_clk      (sys_clk),
    .i_reset    (reset),
    .i_host_elig(host_req & ~host_ack),
    .i_lsu_elig (lsu_req & ~lsu_ack),
    .i_pf_elig  (pf_req & ~pf_ack),
    .i_take     (r_state == ST_IDLE),
    .o_valid    (w_grant_valid),
    .o_id       (w_grant_id)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_grant_valid) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RETURN;
      ST_RETURN: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // ROM writes and the unmapped region never reach the memory port.
  always_comb begin
    w_sel_addr  = host_addr;
    w_sel_we    = host_we;
    w_sel_wdata = host_wdata;
    case (w_grant_id)
      ID_LSU: begin
        w_sel_addr  = lsu_addr;
        w_sel_we    = lsu_we;
        w_sel_wdata = lsu_wdata;
      end
      ID_PF: begin
        w_sel_addr  = pf_addr;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
      end
      default: ;
    endcase
    w_sel_region = decode_region(w_sel_addr);
    w_sel_bad    = (w_sel_region == REG_NONE) || ((w_sel_region == REG_ROM) && w_sel_we);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_bad     <= 1'b0;
      r_id      <= ID_HOST;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ramen     <= 2'b00;
      romen     <= 1'b0;
      gpu_memw  <= 1'b0;
      rdata     <= '0;
      host_ack  <= 1'b0;
      lsu_ack   <= 1'b0;
      pf_ack    <= 1'b0;
      err       <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      lsu_ack  <= 1'b0;
      pf_ack   <= 1'b0;
      err      <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_grant_valid) begin
          r_we      <= w_sel_we;
          r_bad     <= w_sel_bad;
          r_id      <= w_grant_id;
          ram_addr  <= w_sel_addr[9:0];
          ram_wdata <= w_sel_wdata;
          gpu_memw  <= w_sel_we & ~w_sel_bad;
          ramen     <= 2'b00;
          romen     <= 1'b0;
          if (!w_sel_bad) begin
            case (w_sel_region)
              REG_RAM0: ramen <= 2'b01;
              REG_RAM1: ramen <= 2'b10;
              REG_ROM:  romen <= 1'b1;
              default:  ;
            endcase
          end
        end
        ST_ACCESS: begin
          ramen    <= 2'b00;
          romen    <= 1'b0;
          gpu_memw <= 1'b0;
        end
        ST_RETURN: begin
          rdata <= (r_we | r_bad) ? '0 : ram_rdata;
          err   <= r_bad;
          case (r_id)
            ID_HOST: host_ack <= 1'b1;
            ID_LSU:  lsu_ack  <= 1'b1;
            ID_PF:   pf_ack   <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_j_dsp_lbus_arb.sv
// Self-checking bench for j_dsp_lbus_arb: directed scenarios plus random
// contention, compared every cycle against a transaction-level reference model.
module tb_j_dsp_lbus_arb;

  localparam int STREAK = 4;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_req = 1'b0, host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic        lsu_req = 1'b0, lsu_we = 1'b0;
  logic [11:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_ack;
  logic        pf_req = 1'b0;
  logic [11:0] pf_addr = '0;
  logic        pf_ack;
  logic [31:0] rdata;
  logic        err;
  logic [9:0]  ram_addr;
  logic [1:0]  ramen;
  logic        romen;
  logic        gpu_memw;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  always #5 sys_clk = ~sys_clk;

  j_dsp_lbus_arb #(.STREAK_MAX(STREAK)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_ack(lsu_ack),
    .pf_req(pf_req), .pf_addr(pf_addr), .pf_ack(pf_ack),
    .rdata(rdata), .err(err), .ram_addr(ram_addr), .ramen(ramen),
    .romen(romen), .gpu_memw(gpu_memw), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: transaction phase (0 idle, 1 access, 2 return) and expected outputs.
  int          mPhase, mId, mStreak, mLastInt;
  logic        mWe, mBad, mErr, mRomen, mMemw;
  logic [2:0]  mAck;
  logic [31:0] mRdata, mRamWdata;
  logic [9:0]  mRamAddr;
  logic [1:0]  mRamen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mId = 0; mStreak = 0; mLastInt = 2;
    mWe = 0; mBad = 0; mErr = 0; mRomen = 0; mMemw = 0;
    mAck = '0; mRdata = '0; mRamWdata = '0; mRamAddr = '0; mRamen = '0;
  endtask

  // Returns 0 host, 1 lsu, 2 pf, -1 nobody.
  function automatic int pickWinner(input logic h, input logic l, input logic p);
    int internal;
    if (l && p) internal = (mLastInt == 1) ? 2 : 1;
    else        internal = l ? 1 : 2;
    if (h && !(mStreak == STREAK && (l || p))) return 0;
    if (l || p) return internal;
    return -1;
  endfunction

  task automatic modelStep();
    logic h, l, p;
    int w;
    logic [11:0] a;
    if (reset) begin
      modelReset();
      return;
    end
    h = host_req && !mAck[0];
    l = lsu_req && !mAck[1];
    p = pf_req && !mAck[2];
    mAck = '0;
    mErr = 1'b0;
    if (mPhase == 0) begin
      w = pickWinner(h, l, p);
      if (w >= 0) begin
        if (w == 0)      begin a = host_addr; mWe = host_we; mRamWdata = host_wdata; end
        else if (w == 1) begin a = lsu_addr;  mWe = lsu_we;  mRamWdata = lsu_wdata;  end
        else             begin a = pf_addr;   mWe = 1'b0;    mRamWdata = '0;         end
        mId      = w;
        mBad     = (a >= 12'hC00) || (a >= 12'h800 && mWe);
        mRamAddr = a[9:0];
        mRamen   = (mBad || a >= 12'h800) ? 2'b00 : ((a < 12'h400) ? 2'b01 : 2'b10);
        mRomen   = !mBad && a >= 12'h800;
        mMemw    = mWe && !mBad;
        if (w == 0) mStreak = (mStreak < STREAK) ? mStreak + 1 : STREAK;
        else begin
          mStreak  = 0;
          mLastInt = w;
        end
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      mRamen = '0; mRomen = 1'b0; mMemw = 1'b0;
      mPhase = 2;
    end else begin
      mRdata   = (mWe || mBad) ? 32'd0 : ram_rdata;
      mAck[mId] = 1'b1;
      mErr     = mBad;
      mPhase   = 0;
    end
  endtask

  task automatic checkOutput();
    check("acks", {29'd0, pf_ack, lsu_ack, host_ack}, {29'd0, mAck});
    check("err", err, mErr);
    check("rdata", rdata, mRdata);
    check("ramen", ramen, mRamen);
    check("romen", romen, mRomen);
    check("gpu_memw", gpu_memw, mMemw);
    check("ram_addr", ram_addr, mRamAddr);
    check("ram_wdata", ram_wdata, mRamWdata);
  endtask

  // Inputs are already set at a falling edge; advance one cycle and compare.
  task automatic applyStimulus();
    modelStep();
    @(negedge sys_clk);
    checkOutput();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (host_ack) host_req = 1'b0;
      if (lsu_ack)  lsu_req  = 1'b0;
      if (pf_ack)   pf_req   = 1'b0;
      if (!host_req && !lsu_req && !pf_req) break;
      applyStimulus();
    end
    check("drain_timeout", {29'd0, host_req, lsu_req, pf_req}, 32'd0);
  endtask

  task automatic driveRandom();
    if (host_req && host_ack) begin
      if ($urandom_range(0, 1) == 0) host_req = 1'b0;
      else begin
        host_addr = 12'($urandom_range(0, 4095)); host_we = 1'($urandom_range(0, 1));
        host_wdata = $urandom;
      end
    end else if (!host_req && $urandom_range(0, 3) == 0) begin
      host_req = 1'b1;
      host_addr = 12'($urandom_range(0, 4095)); host_we = 1'($urandom_range(0, 1));
      host_wdata = $urandom;
    end
    if (lsu_req && lsu_ack) begin
      if ($urandom_range(0, 1) == 0) lsu_req = 1'b0;
      else begin
        lsu_addr = 12'($urandom_range(0, 4095)); lsu_we = 1'($urandom_range(0, 1));
        lsu_wdata = $urandom;
      end
    end else if (!lsu_req && $urandom_range(0, 2) == 0) begin
      lsu_req = 1'b1;
      lsu_addr = 12'($urandom_range(0, 4095)); lsu_we = 1'($urandom_range(0, 1));
      lsu_wdata = $urandom;
    end
    if (pf_req && pf_ack) begin
      if ($urandom_range(0, 1) == 0) pf_req = 1'b0;
      else pf_addr = 12'($urandom_range(0, 4095));
    end else if (!pf_req && $urandom_range(0, 2) == 0) begin
      pf_req = 1'b1;
      pf_addr = 12'($urandom_range(0, 4095));
    end
    ram_rdata = $urandom;
  endtask

  initial begin
    modelReset();
    @(negedge sys_clk);
    reset = 1'b1;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    applyStimulus();

    // Single lsu read from bank 1.
    ram_rdata = 32'hDEADBEEF;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h405;
    applyStimulus();
    check("t1_ramen", ramen, 2'b10);
    check("t1_ram_addr", ram_addr, 10'h005);
    applyStimulus();
    applyStimulus();
    check("t1_lsu_ack", lsu_ack, 1'b1);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_other_acks", {host_ack, pf_ack}, 2'b00);
    lsu_req = 1'b0;
    applyStimulus();

    // Host write to bank 0.
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h010; host_wdata = 32'h12345678;
    applyStimulus();
    check("t2_memw", gpu_memw, 1'b1);
    check("t2_ramen", ramen, 2'b01);
    check("t2_wdata", ram_wdata, 32'h12345678);
    applyStimulus();
    applyStimulus();
    check("t2_ack", host_ack, 1'b1);
    check("t2_rdata", rdata, 32'd0);
    check("t2_err", err, 1'b0);
    host_req = 1'b0;
    applyStimulus();

    // Host write to ROM is rejected with err.
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h800;
    applyStimulus();
    check("t3_enables", {29'd0, romen, ramen, gpu_memw}, 32'd0);
    applyStimulus();
    applyStimulus();
    check("t3_ack_err", {host_ack, err}, 2'b11);
    host_req = 1'b0;
    applyStimulus();

    // Saturate the host streak, then present host and lsu together.
    for (int i = 0; i < 4; i++) begin
      host_req = 1'b1; host_we = 1'b0; host_addr = 12'(i * 4);
      applyStimulus(); applyStimulus(); applyStimulus();
      host_req = 1'b0;
      applyStimulus();
    end
    host_req = 1'b1; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h020;
    applyStimulus(); applyStimulus(); applyStimulus();
    check("streak_lsu_wins", {host_ack, lsu_ack}, 2'b01);
    lsu_req = 1'b0;
    applyStimulus(); applyStimulus(); applyStimulus();
    check("streak_host_next", host_ack, 1'b1);
    host_req = 1'b0;
    applyStimulus();
    host_req = 1'b1; lsu_req = 1'b1;
    applyStimulus(); applyStimulus(); applyStimulus();
    check("host_priority", {host_ack, lsu_ack}, 2'b10);
    host_req = 1'b0;
    drain();

    // All three requesting continuously.
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h100;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h500;
    pf_req = 1'b1; pf_addr = 12'h900;
    for (int i = 0; i < 36; i++) begin
      ram_rdata = $urandom;
      applyStimulus();
    end
    drain();

    // Random contention.
    for (int i = 0; i < 400; i++) begin
      driveRandom();
      applyStimulus();
    end
    drain();

    // Reset during RETURN aborts the access.
    host_req = 1'b1; host_we = 1'b0; host_addr = 12'h0AA;
    applyStimulus();
    applyStimulus();
    reset = 1'b1; host_req = 1'b0;
    applyStimulus();
    check("rst_no_ack", {29'd0, host_ack, lsu_ack, pf_ack}, 32'd0);
    check("rst_enables", {29'd0, romen, ramen}, 32'd0);
    reset = 1'b0;
    applyStimulus();
    check("rst_still_no_ack", host_ack, 1'b0);
    ram_rdata = 32'hCAFEF00D;
    pf_req = 1'b1; pf_addr = 12'h123;
    applyStimulus(); applyStimulus(); applyStimulus();
    check("pf_after_rst_ack", pf_ack, 1'b1);
    check("pf_after_rst_rdata", rdata, 32'hCAFEF00D);
    pf_req = 1'b0;
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
